count_display: RTL
==================

COUNT_DISPLAY -- requirements
Module: count_display

Interface
REQ-001 Parameter: REFRESH_BITS, default 16, width of the digit-refresh prescaler; one digit advance per 2^REFRESH_BITS clk cycles.
REQ-002 clk  input  1  sole clock; all state changes on posedge clk.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 value  input  8  unsigned binary count to display (0..255), driven by the counter block.
REQ-005 bcd  output  12  latched decimal result {hundreds, tens, ones}, 4 bits each.
REQ-006 valid  output  1  one-cycle pulse when bcd/display register updates.
REQ-007 an  output  4  digit anode enables, active-low; an[3] permanently 1.
REQ-008 seg  output  7  segment drive {g,f,e,d,c,b,a}, active-low.
REQ-009 dp  output  1  decimal point, active-low; permanently 1.

Function
REQ-010 Converter FSM states: IDLE, SHIFT, LOAD; each state transition on posedge clk.
REQ-011 IDLE: sample value into an 8-bit shift register, clear 12-bit BCD scratch and 3-bit shift counter; go to SHIFT; no other action.
REQ-012 SHIFT: per cycle, add 3 to every scratch BCD nibble >= 5, then shift {scratch, shift register} left by 1; increment shift counter; after the 8th shift go to LOAD.
REQ-013 LOAD: copy scratch to bcd, assert valid for this one cycle, go to IDLE.
REQ-014 Conversion period fixed at 10 cycles (1 IDLE + 8 SHIFT + 1 LOAD); bcd reflects value sampled 9 cycles earlier; changes to value during SHIFT/LOAD are ignored until next IDLE.
REQ-015 bcd nibbles always 0..9; hundreds 0..2; no overflow possible for 8-bit input.
REQ-016 Scan: REFRESH_BITS-bit prescaler increments every cycle, wraps at all-ones; 2-bit digit index advances 0->1->2->0 on each prescaler wrap; index 3 never reached.
REQ-017 an = 4'b1110, 4'b1101, 4'b1011 for digit index 0 (ones), 1 (tens), 2 (hundreds); exactly one of an[2:0] low at all times.
REQ-018 seg decoded combinationally from the bcd nibble selected by digit index: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-019 Display updates only from the latched bcd, never from scratch; no intermediate digit visible during SHIFT.
REQ-020 Scan and conversion are independent; a bcd update coinciding with a digit advance shows the new value on the new digit in the same cycle.

Reset
REQ-021 rst asserted: state IDLE, shift/scratch/shift counter 0, bcd 12'h000, valid 0, prescaler 0, digit index 0, an 4'b1110, seg 1000000, dp 1.
REQ-022 rst mid-conversion aborts immediately; bcd not updated; first valid after release appears on the 10th posedge after rst deasserts.

Configuration
REQ-023 Macro LEADING_ZERO_BLANK_EN: when defined, hundreds digit drives seg 1111111 if hundreds=0, tens digit drives seg 1111111 if hundreds=0 and tens=0; ones digit never blanked; an scanning unchanged.
REQ-024 Without LEADING_ZERO_BLANK_EN all three digits always show their decimal value, including leading zeros.

Verification
REQ-025 Reset release, value=8'd0 held -> valid every 10 cycles, bcd=12'h000, seg=1000000 on all digits.
REQ-026 value=8'd255 -> after 9 cycles from sample bcd=12'h255, valid pulse; REFRESH_BITS=4: an sequence 1110,1101,1011 every 16 cycles, seg 0010010,0010010,0100100.
REQ-027 value 8'd128 switched to 8'd7 mid-SHIFT -> first bcd=12'h128, next bcd=12'h007.
REQ-028 rst pulsed during 5th SHIFT cycle with value=8'd99 -> outputs at reset values, no valid, bcd=12'h099 with valid 10 cycles after release.
REQ-029 LEADING_ZERO_BLANK_EN defined, value=8'd7 -> hundreds and tens seg=1111111, ones seg=1111000; value=8'd105 -> tens shows 1000000 (not blanked).
REQ-030 Sweep value 0..255 -> every bcd equals decimal of sampled value, every nibble <= 9.

Source files
------------

// File: rtl/count_display.sv
// Binary-to-BCD converter (shift-and-add-3 FSM) driving a 3-digit multiplexed 7-segment display.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero hundreds/tens digits.
module count_display #(
    parameter int REFRESH_BITS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  value,
    output logic [11:0] bcd,
    output logic        valid,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t                  state;
    logic [7:0]              shift_reg;
    logic [11:0]             scratch;
    logic [11:0]             scratch_adj;
    logic [2:0]              shift_cnt;
    logic [REFRESH_BITS-1:0] prescaler;
    logic [1:0]              digit;
    logic [3:0]              nibble;
    logic                    blank;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Add-3 correction applied to every scratch nibble before each shift
    always_comb begin
        scratch_adj = {add3(scratch[11:8]), add3(scratch[7:4]), add3(scratch[3:0])};
    end

    // Converter FSM: sample, eight shift/correct steps, then latch into bcd
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= 8'd0;
            scratch   <= 12'd0;
            shift_cnt <= 3'd0;
            bcd       <= 12'h000;
            valid     <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    shift_reg <= value;
                    scratch   <= 12'd0;
                    shift_cnt <= 3'd0;
                    state     <= SHIFT;
                end
                SHIFT: begin
                    {scratch, shift_reg} <= {scratch_adj[10:0], shift_reg, 1'b0};
                    shift_cnt            <= shift_cnt + 3'd1;
                    if (shift_cnt == 3'd7) begin
                        state <= LOAD;
                    end else begin
                        state <= SHIFT;
                    end
                end
                LOAD: begin
                    bcd   <= scratch;
                    valid <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Refresh prescaler and digit index; digit advances on prescaler wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            digit     <= 2'd0;
        end else begin
            prescaler <= prescaler + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
            if (&prescaler) begin
                digit <= (digit == 2'd2) ? 2'd0 : (digit + 2'd1);
            end else begin
                digit <= digit;
            end
        end
    end

    // Digit select and segment decode from the latched bcd only
    always_comb begin
        nibble = bcd[3:0];
        an     = 4'b1110;
        blank  = 1'b0;
        case (digit)
            2'd0: begin
                nibble = bcd[3:0];
                an     = 4'b1110;
            end
            2'd1: begin
                nibble = bcd[7:4];
                an     = 4'b1101;
`ifdef LEADING_ZERO_BLANK_EN
                blank  = (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
`endif
            end
            2'd2: begin
                nibble = bcd[11:8];
                an     = 4'b1011;
`ifdef LEADING_ZERO_BLANK_EN
                blank  = (bcd[11:8] == 4'd0);
`endif
            end
            default: begin
                nibble = bcd[3:0];
                an     = 4'b1110;
            end
        endcase
        if (blank) begin
            seg = 7'b1111111;
        end else begin
            seg = seg_decode(nibble);
        end
    end

    assign dp = 1'b1;

endmodule
